// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - control, table-write and generator signals of the note sequencer
interface note_sequencer_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned IW = $clog2(DEPTH);

    logic          start;
    logic          stop;
    logic          loop_en;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [13:0]   wr_freq;
    logic [15:0]   wr_dur;
    logic          wave_zero;
    logic [13:0]   freq_out;
    logic          note_active;
    logic [IW-1:0] note_index;
    logic          busy;
    logic          done;

    modport master (
        output start, stop, loop_en, wr_en, wr_addr, wr_freq, wr_dur, wave_zero,
        input  freq_out, note_active, note_index, busy, done
    );

    modport slave (
        input  start, stop, loop_en, wr_en, wr_addr, wr_freq, wr_dur, wave_zero,
        output freq_out, note_active, note_index, busy, done
    );
endinterface

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - steps a programmable note table, releasing notes on generator zero crossings
module note_sequencer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned GAP_TICKS   = 320,
    parameter int unsigned RELEASE_MAX = 255,
    parameter int unsigned FREQ_MIN    = 100,
    parameter int unsigned FREQ_MAX    = 8000
) (
    input logic              CLK_32KHz,
    input logic              reset,
    note_sequencer_if.slave  bus
);
    localparam int unsigned   IW       = $clog2(DEPTH);
    localparam logic [13:0]   FMIN     = 14'(FREQ_MIN);
    localparam logic [13:0]   FMAX     = 14'(FREQ_MAX);
    localparam logic [15:0]   GAP_LAST = (GAP_TICKS == 0) ? 16'd0 : 16'(GAP_TICKS - 1);
    localparam logic [15:0]   REL_LAST = (RELEASE_MAX == 0) ? 16'd0 : 16'(RELEASE_MAX - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_PLAY, S_RELEASE, S_GAP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [13:0]   freq_q, freq_d;
    logic          active_q, active_d;
    logic [15:0]   dcnt_q, dcnt_d;
    logic [15:0]   rcnt_q, rcnt_d;
    logic [15:0]   gcnt_q, gcnt_d;
    logic          advance;

    logic [13:0]   tbl_freq_q [DEPTH];
    logic [15:0]   tbl_dur_q  [DEPTH];
    logic [13:0]   cur_freq;
    logic [15:0]   cur_dur;

    function automatic logic [13:0] clamp(input logic [13:0] f);
        if (f == 14'd0)      return 14'd0;
        else if (f < FMIN)   return FMIN;
        else if (f > FMAX)   return FMAX;
        else                 return f;
    endfunction

    always_ff @(posedge CLK_32KHz) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_freq_q[i] <= '0;
                tbl_dur_q[i]  <= '0;
            end
        end else if (bus.wr_en) begin
            tbl_freq_q[bus.wr_addr] <= bus.wr_freq;
            tbl_dur_q[bus.wr_addr]  <= bus.wr_dur;
        end
    end

    assign cur_freq = tbl_freq_q[idx_q];
    assign cur_dur  = tbl_dur_q[idx_q];

    always_ff @(posedge CLK_32KHz) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            freq_q   <= '0;
            active_q <= 1'b0;
            dcnt_q   <= '0;
            rcnt_q   <= '0;
            gcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            freq_q   <= freq_d;
            active_q <= active_d;
            dcnt_q   <= dcnt_d;
            rcnt_q   <= rcnt_d;
            gcnt_q   <= gcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        freq_d   = freq_q;
        active_d = active_q;
        dcnt_d   = dcnt_q;
        rcnt_d   = rcnt_q;
        gcnt_d   = gcnt_q;
        advance  = 1'b0;

        case (state_q)
            S_IDLE: begin
                freq_d   = '0;
                active_d = 1'b0;
                if (bus.start) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Looping back from a mid-table end marker; an empty song (idx 0) must finish.
                if (cur_dur == 16'd0) begin
                    if (bus.loop_en && idx_q != '0) idx_d = '0;
                    else                            state_d = S_DONE;
                end else begin
                    state_d  = S_PLAY;
                    freq_d   = clamp(cur_freq);
                    active_d = (cur_freq != 14'd0);
                    dcnt_d   = cur_dur;
                end
            end
            S_PLAY: begin
                if (dcnt_q <= 16'd1) begin
                    state_d = S_RELEASE;
                    rcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q - 16'd1;
                end
            end
            S_RELEASE: begin
                if (bus.wave_zero || freq_q == 14'd0 || rcnt_q >= REL_LAST) begin
                    freq_d   = '0;
                    active_d = 1'b0;
                    if (GAP_TICKS == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        gcnt_d  = '0;
                    end
                end else begin
                    rcnt_d = rcnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) advance = 1'b1;
                else                    gcnt_d  = gcnt_q + 16'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (idx_q == IDX_LAST) begin
                if (bus.loop_en) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DONE;
                end
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_FETCH;
            end
        end

        // Abort wins over everything, including start and a pending release.
        if (bus.stop) begin
            state_d  = S_IDLE;
            idx_d    = idx_q;
            freq_d   = '0;
            active_d = 1'b0;
        end
    end

    assign bus.freq_out    = freq_q;
    assign bus.note_active = active_q;
    assign bus.note_index  = idx_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - randomized bench for note_sequencer against a cycle-trace reference model
module tb_note_sequencer;
    localparam int DEPTH = 16;
    localparam int GAP   = 2;
    localparam int RMAX  = 255;
    localparam int WZN   = 6000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    note_sequencer_if #(.DEPTH(DEPTH)) bus ();

    note_sequencer #(
        .DEPTH(DEPTH), .GAP_TICKS(GAP), .RELEASE_MAX(RMAX), .FREQ_MIN(100), .FREQ_MAX(8000)
    ) dut (
        .CLK_32KHz(clk),
        .reset(reset),
        .bus(bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [13:0] tbl_f [DEPTH];
    logic [15:0] tbl_d [DEPTH];
    bit          wz [WZN];
    logic [20:0] exp_q [$];
    int          fetch_cyc [DEPTH];
    int          wr_cyc = 0;
    logic [13:0] new5_f;
    logic [15:0] new5_d;
    int          cnt_nz, cnt_act, cnt_busy, cnt_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [20:0] pack(input logic [13:0] f, input bit a, input int i,
                                         input bit b, input bit d);
        return {f, a, 4'(i), b, d};
    endfunction

    function automatic logic [20:0] obs();
        return {bus.freq_out, bus.note_active, bus.note_index, bus.busy, bus.done};
    endfunction

    function automatic logic [13:0] model_clamp(input logic [13:0] f);
        if (f == 0)         return 14'd0;
        else if (f < 100)   return 14'd100;
        else if (f > 8000)  return 14'd8000;
        else                return f;
    endfunction

    // Expected per-cycle outputs, cycle 1 = first cycle after the start edge.
    function automatic void build(input bit loop, input int limit);
        int idx;
        int r;
        logic [13:0] f;
        exp_q.delete();
        idx = 0;
        for (int k = 0; k < DEPTH; k++) fetch_cyc[k] = 0;
        forever begin
            if (exp_q.size() > limit) return;
            if (fetch_cyc[idx] == 0) fetch_cyc[idx] = exp_q.size() + 1;
            exp_q.push_back(pack(14'd0, 1'b0, idx, 1'b1, 1'b0));
            if (tbl_d[idx] == 0) begin
                if (loop && idx != 0) begin
                    idx = 0;
                    continue;
                end
                break;
            end
            f = model_clamp(tbl_f[idx]);
            for (int k = 0; k < int'(tbl_d[idx]); k++)
                exp_q.push_back(pack(f, f != 0, idx, 1'b1, 1'b0));
            r = 0;
            forever begin
                exp_q.push_back(pack(f, f != 0, idx, 1'b1, 1'b0));
                if (wz[exp_q.size()] || f == 0 || r == RMAX - 1) break;
                r++;
            end
            for (int k = 0; k < GAP; k++) exp_q.push_back(pack(14'd0, 1'b0, idx, 1'b1, 1'b0));
            if (idx == DEPTH - 1) begin
                if (loop) idx = 0;
                else break;
            end else begin
                idx++;
            end
        end
        exp_q.push_back(pack(14'd0, 1'b0, idx, 1'b1, 1'b1));
        exp_q.push_back(pack(14'd0, 1'b0, idx, 1'b0, 1'b0));
    endfunction

    function automatic void fill_wz(input int mode);
        for (int i = 0; i < WZN; i++)
            wz[i] = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
    endfunction

    task automatic write_entry(input int a, input logic [13:0] f, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(a);
        bus.wr_freq = f;
        bus.wr_dur  = d;
        @(posedge clk);
        @(negedge clk);
        bus.wr_en = 1'b0;
        tbl_f[a] = f;
        tbl_d[a] = d;
    endtask

    task automatic run(input int song, input bit loop, input int stop_at);
        int n;
        logic [20:0] last;
        if (stop_at > 0 && stop_at < exp_q.size()) begin
            last = exp_q[stop_at-1];
            while (exp_q.size() > stop_at) void'(exp_q.pop_back());
            exp_q.push_back({14'd0, 1'b0, last[5:2], 1'b0, 1'b0});
        end
        n = exp_q.size();
        cnt_nz = 0; cnt_act = 0; cnt_busy = 0; cnt_done = 0;
        bus.loop_en = loop;
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= n; cyc++) begin
            check($sformatf("song%0d_cyc%0d", song, cyc), 32'(obs()), 32'(exp_q[cyc-1]));
            if (bus.freq_out != 0) cnt_nz++;
            if (bus.note_active)   cnt_act++;
            if (bus.busy)          cnt_busy++;
            if (bus.done)          cnt_done++;
            bus.wave_zero = wz[cyc];
            bus.stop      = (cyc == stop_at);
            bus.start     = exp_q[cyc-1][1] && ($urandom_range(0, 7) == 0);
            if (cyc == wr_cyc) begin
                bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_freq = new5_f; bus.wr_dur = new5_d;
            end else if (wr_cyc != 0 && cyc == wr_cyc + 1) begin
                bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_freq = 14'd1111; bus.wr_dur = 16'd9;
            end else begin
                bus.wr_en = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.start = 1'b0; bus.stop = 1'b0; bus.wr_en = 1'b0; bus.wave_zero = 1'b0;
    endtask

    initial begin
        int n;
        int stop_at;
        bit loop;
        bus.start = 0; bus.stop = 0; bus.loop_en = 0; bus.wr_en = 0; bus.wr_addr = 0;
        bus.wr_freq = 0; bus.wr_dur = 0; bus.wave_zero = 0;
        for (int k = 0; k < DEPTH; k++) begin tbl_f[k] = 0; tbl_d[k] = 0; end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_outputs", 32'(obs()), 32'd0);

        // Empty song after reset, even with looping requested
        fill_wz(2);
        build(1'b1, 200);
        run(1, 1'b1, 0);
        check("empty_done_count", cnt_done, 1);
        check("empty_busy_cycles", cnt_busy, 2);
        check("empty_freq_cycles", cnt_nz, 0);

        // 440 Hz note, a rest, end marker
        write_entry(0, 14'd440, 16'd10);
        write_entry(1, 14'd0, 16'd5);
        write_entry(2, 14'd77, 16'd0);
        fill_wz(1);
        build(1'b0, 1000);
        run(2, 1'b0, 0);
        check("t2_freq_cycles", cnt_nz, 11);
        check("t2_active_cycles", cnt_act, 11);
        check("t2_done_count", cnt_done, 1);

        // Clamping
        write_entry(0, 14'd9000, 16'd4);
        write_entry(1, 14'd50, 16'd4);
        write_entry(2, 14'd8000, 16'd4);
        write_entry(3, 14'd0, 16'd0);
        fill_wz(2);
        build(1'b0, 1000);
        run(3, 1'b0, 0);

        // Release waits: late zero crossing, then a generator that never crosses
        write_entry(0, 14'd1234, 16'd5);
        write_entry(1, 14'd0, 16'd0);
        fill_wz(0);
        wz[27] = 1'b1;
        build(1'b0, 2000);
        run(4, 1'b0, 0);
        check("t4_late_zero_cycles", cnt_nz, 26);
        fill_wz(0);
        build(1'b0, 2000);
        run(5, 1'b0, 0);
        check("t4_stuck_zero_cycles", cnt_nz, 5 + RMAX);

        // Looping two-note song, aborted mid-note
        write_entry(0, 14'd300, 16'd3);
        write_entry(1, 14'd600, 16'd3);
        write_entry(2, 14'd5, 16'd0);
        fill_wz(2);
        build(1'b1, 150);
        stop_at = 0;
        for (int s = 60; s < exp_q.size() && stop_at == 0; s++)
            if (exp_q[s-1][20:7] != 0) stop_at = s;
        run(6, 1'b1, stop_at);
        check("t5_no_done", cnt_done, 0);
        check("t5_stop_seen", 32'(stop_at > 0), 32'd1);

        // stop beats start while idle
        bus.start = 1'b1; bus.stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stop_prio_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0; bus.stop = 1'b0;

        // Full table, write to a later entry while entry 3 plays
        for (int k = 0; k < DEPTH; k++)
            write_entry(k, 14'($urandom_range(0, 9000)), 16'($urandom_range(1, 4)));
        new5_f = 14'd2500;
        new5_d = 16'd6;
        tbl_f[5] = new5_f;
        tbl_d[5] = new5_d;
        fill_wz(2);
        build(1'b0, 5000);
        wr_cyc = fetch_cyc[3] + 1;
        run(7, 1'b0, 0);
        wr_cyc = 0;
        tbl_f[3] = 14'd1111;
        tbl_d[3] = 16'd9;
        check("t6_done_count", cnt_done, 1);

        // Random songs
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, DEPTH);
            for (int k = 0; k < DEPTH; k++) begin
                logic [13:0] f;
                case ($urandom_range(0, 3))
                    0:       f = 14'd0;
                    1:       f = 14'($urandom_range(1, 99));
                    2:       f = 14'($urandom_range(100, 8000));
                    default: f = 14'($urandom_range(8001, 16383));
                endcase
                if (k < n)       write_entry(k, f, 16'($urandom_range(1, 5)));
                else if (k == n) write_entry(k, f, 16'd0);
            end
            loop = 1'($urandom_range(0, 1));
            fill_wz($urandom_range(0, 3) == 0 ? 1 : 2);
            build(loop, 250);
            if (loop)                          stop_at = $urandom_range(3, 250);
            else if ($urandom_range(0, 2) == 0) stop_at = $urandom_range(2, exp_q.size());
            else                               stop_at = 0;
            run(10 + it, loop, stop_at);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
